// File: rtl/stk_pkg.sv
// Shared types and helpers for the stk family of multi-channel LIFO engines.
// Opcode encoding, response layout at the default configuration, request decode.
package stk_pkg;

    typedef enum logic [2:0] {
        NOP   = 3'd0,
        PUSH  = 3'd1,
        POP   = 3'd2,
        PEEK  = 3'd3,
        CLEAR = 3'd4
    } mc_opcode_t;

    localparam int MC_W     = 128;
    localparam int MC_CNT_W = 5;

    typedef struct packed {
        logic                vld;
        logic [MC_W-1:0]     dat;
        logic                err;
        logic [MC_CNT_W-1:0] cnt;
    } mc_rsp_t;

    // Reserved encodings 5..7 behave exactly like NOP.
    function automatic logic is_req(input logic [2:0] op);
        is_req = (op >= 3'd1) && (op <= 3'd4);
    endfunction

endpackage

// File: rtl/stk_rr_arb.sv
// Round-robin arbiter: one-hot grant, search starts at the pointer,
// pointer moves just past the winner when en is high and a grant is made.
module stk_rr_arb #(
    parameter int  N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    logic [PW-1:0] ptr_r;
    int            dist_s;
    int            best_s;
    int            win_s;
    logic          take_s;

    // Pick the requester with the smallest rotational distance from the pointer.
    always_comb begin
        best_s = N;
        win_s  = 0;
        dist_s = 0;
        take_s = 1'b0;
        for (int j = 0; j < N; j++) begin
            dist_s = (j >= int'(ptr_r)) ? (j - int'(ptr_r)) : (j - int'(ptr_r) + N);
            take_s = req[j] && (dist_s < best_s);
            win_s  = take_s ? j : win_s;
            best_s = take_s ? dist_s : best_s;
        end
        for (int j = 0; j < N; j++) begin
            gnt[j] = (best_s < N) && (win_s == j);
        end
    end

    // Pointer register; holds when nothing is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (en && (best_s < N)) begin
            ptr_r <= PW'((win_s + 1) % N);
        end
    end

endmodule

// File: rtl/stk_mc.sv
// Multi-channel LIFO engine: ENGS_N requesters share one command port through a
// round-robin arbiter; each owns a private DEPTH-entry stack, response one cycle later.
module stk_mc
    import stk_pkg::*;
#(
    parameter int  ENGS_N = 4,
    parameter int  W      = 128,
    parameter int  DEPTH  = 16,
    localparam int CW     = $clog2(DEPTH) + 1,
    localparam int AW     = $clog2(DEPTH),
    localparam int GW     = (ENGS_N > 1) ? $clog2(ENGS_N) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ENGS_N-1:0][2:0]   i_cmd_opcode,
    input  logic [ENGS_N-1:0][W-1:0] i_cmd_dat,
    output logic [ENGS_N-1:0]        o_cmd_ack,
    output logic [ENGS_N-1:0]        o_rsp_vld,
    output logic [W-1:0]             o_rsp_dat,
    output logic                     o_rsp_err,
    output logic [CW-1:0]            o_rsp_cnt
);

    typedef struct packed {
        logic [ENGS_N-1:0] vld;
        logic [W-1:0]      dat;
        logic              err;
        logic [CW-1:0]     cnt;
    } rsp_t;

    logic [ENGS_N-1:0] req_s;
    logic [ENGS_N-1:0] gnt_s;
    logic              any_gnt_s;
    logic [GW-1:0]     gidx_s;
    mc_opcode_t        op_s;
    logic [W-1:0]      dat_s;
    logic [CW-1:0]     p_s;
    logic [CW-1:0]     nxt_p_s;
    logic [AW-1:0]     rd_idx_s;
    logic [AW-1:0]     wr_idx_s;
    logic              wr_en_s;
    rsp_t              rsp_s;
    rsp_t              rsp_r;
    logic [CW-1:0]     ptr_r [ENGS_N];
    logic [W-1:0]      mem_r [ENGS_N][DEPTH];

    // Request decode; nothing is requested while reset is held.
    always_comb begin
        for (int e = 0; e < ENGS_N; e++) begin
            req_s[e] = ~rst & is_req(i_cmd_opcode[e]);
        end
    end

    stk_rr_arb #(.N(ENGS_N)) u_arb (
        .clk (clk),
        .rst (rst),
        .en  (any_gnt_s),
        .req (req_s),
        .gnt (gnt_s)
    );

    // One-hot grant to binary index.
    always_comb begin
        gidx_s = '0;
        for (int e = 0; e < ENGS_N; e++) begin
            gidx_s = gnt_s[e] ? GW'(e) : gidx_s;
        end
        any_gnt_s = |gnt_s;
    end

    // Execute the granted op against its stack; updates land on the next edge,
    // so an op in the following cycle already sees them.
    always_comb begin
        op_s      = mc_opcode_t'(i_cmd_opcode[gidx_s]);
        dat_s     = i_cmd_dat[gidx_s];
        p_s       = ptr_r[gidx_s];
        rd_idx_s  = AW'(p_s - CW'(1));
        wr_idx_s  = p_s[AW-1:0];
        nxt_p_s   = p_s;
        wr_en_s   = 1'b0;
        rsp_s     = '0;
        rsp_s.vld = gnt_s;
        if (any_gnt_s) begin
            case (op_s)
                PUSH: begin
                    if (p_s < CW'(DEPTH)) begin
                        wr_en_s = 1'b1;
                        nxt_p_s = p_s + CW'(1);
                    end else begin
                        rsp_s.err = 1'b1;
                    end
                end
                POP, PEEK: begin
                    if (p_s != '0) begin
                        rsp_s.dat = mem_r[gidx_s][rd_idx_s];
                        nxt_p_s   = (op_s == POP) ? (p_s - CW'(1)) : p_s;
                    end else begin
                        rsp_s.err = 1'b1;
                    end
                end
                CLEAR: begin
                    nxt_p_s = '0;
                end
                default: begin
                    nxt_p_s = p_s;
                end
            endcase
            rsp_s.cnt = nxt_p_s;
        end else begin
            rsp_s.cnt = '0;
        end
    end

    // Stack pointers and the single response stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_r <= '0;
            for (int e = 0; e < ENGS_N; e++) begin
                ptr_r[e] <= '0;
            end
        end else begin
            rsp_r <= rsp_s;
            if (any_gnt_s) begin
                ptr_r[gidx_s] <= nxt_p_s;
            end
        end
    end

    // Stack storage; deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[gidx_s][wr_idx_s] <= dat_s;
        end
    end

    // A response still in flight when reset arrives is suppressed.
    always_comb begin
        o_cmd_ack = gnt_s;
        if (rst) begin
            o_rsp_vld = '0;
            o_rsp_dat = '0;
            o_rsp_err = 1'b0;
            o_rsp_cnt = '0;
        end else begin
            o_rsp_vld = rsp_r.vld;
            o_rsp_dat = rsp_r.dat;
            o_rsp_err = rsp_r.err;
            o_rsp_cnt = rsp_r.cnt;
        end
    end

endmodule
